// File: rtl/sync_debounce_bank.sv
// Bank of independent synchronizer + debounce channels.
// Each raw input passes through a STAGES-deep flop chain. The registered
// output only follows the synchronized level after DB_CYCLES consecutive
// enabled cycles of disagreement, and each change emits a one-cycle rise/fall pulse.

module sync_debounce_lane #(
  parameter int   STAGES    = 2,
  parameter int   DB_CYCLES = 4,
  parameter logic RST_BIT   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  input  logic en_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o,
  output logic evt_o
);
  localparam int            CW      = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [STAGES-1:0] sync_q;
  logic              sync;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              out_q, out_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  // Synchronizer chain. It keeps shifting regardless of the enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {STAGES{RST_BIT}};
    else        sync_q <= {sync_q[STAGES-2:0], sig_i};
  end

  assign sync = sync_q[STAGES-1];

  // Debounce decision. A disagreement must persist for DB_CYCLES enabled
  // cycles. Agreement clears the count, and a disabled cycle freezes it.
  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (en_i) begin
      if (sync == out_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        out_d  = sync;
        rise_d = sync;
        fall_d = ~sync;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Counter, debounced level and edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      out_q  <= RST_BIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out_o  = out_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign evt_o  = rise_d | fall_d;
endmodule

module sync_debounce_bank #(
  parameter int                  CHANNELS  = 4,
  parameter int                  STAGES    = 2,
  parameter int                  DB_CYCLES = 4,
  parameter logic [CHANNELS-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] sig_in,
  input  logic                en,
  output logic [CHANNELS-1:0] sig_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_edge
);
  logic [CHANNELS-1:0] evt;
  logic                any_q, any_d;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    sync_debounce_lane #(
      .STAGES   (STAGES),
      .DB_CYCLES(DB_CYCLES),
      .RST_BIT  (RESET_VAL[c])
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .sig_i (sig_in[c]),
      .en_i  (en),
      .out_o (sig_out[c]),
      .rise_o(rise[c]),
      .fall_o(fall[c]),
      .evt_o (evt[c])
    );
  end

  assign any_d = |evt;

  // Aggregate edge flag. It is registered alongside the per-lane pulses so all of them line up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_q <= 1'b0;
    else        any_q <= any_d;
  end

  assign any_edge = any_q;
endmodule

// File: tb/tb_sync_debounce_bank.sv
// Bench for sync_debounce_bank. It uses a vector table, hand sequences for the
// reset/enable corner cases, and a randomized run checked against a reference model.

module tb_sync_debounce_bank;
  localparam int         CH = 4;
  localparam int         ST = 2;
  localparam int         DB = 4;
  localparam logic [3:0] RV = 4'b1000;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       en    = 1'b1;
  logic [3:0] sig_in = RV;
  logic [3:0] sig_out, rise, fall;
  logic       any_edge;

  int checks = 0;
  int errors = 0;

  sync_debounce_bank #(
    .CHANNELS (CH),
    .STAGES   (ST),
    .DB_CYCLES(DB),
    .RESET_VAL(RV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sig_in  (sig_in),
    .en      (en),
    .sig_out (sig_out),
    .rise    (rise),
    .fall    (fall),
    .any_edge(any_edge)
  );

  always #5 clk = ~clk;

  // Reference model. The sync chain is a delay line of input samples. Each
  // channel counts enabled cycles in which the delayed input disagrees with the
  // output. Agreement clears that count, and the output flips once the count reaches DB.
  logic [3:0] m_pipe [ST];
  logic [3:0] m_out, m_rise, m_fall;
  int         m_cnt [CH];
  bit         model_on = 1'b0;

  function automatic void model_reset();
    for (int k = 0; k < ST; k++) m_pipe[k] = RV;
    m_out  = RV;
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < CH; c++) m_cnt[c] = 0;
  endfunction

  function automatic void model_edge(logic [3:0] vin, logic e);
    logic [3:0] s;
    s      = m_pipe[ST-1];
    m_rise = '0;
    m_fall = '0;
    if (e) begin
      for (int c = 0; c < CH; c++) begin
        if (s[c] == m_out[c]) m_cnt[c] = 0;
        else begin
          m_cnt[c] = m_cnt[c] + 1;
          if (m_cnt[c] == DB) begin
            m_out[c] = s[c];
            if (s[c]) m_rise[c] = 1'b1;
            else      m_fall[c] = 1'b1;
            m_cnt[c] = 0;
          end
        end
      end
    end
    for (int k = ST-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = vin;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (model_on && rst_n) model_edge(sig_in, en);
    #1;
  endtask

  task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_all(string nm, logic [3:0] eo, logic [3:0] er, logic [3:0] ef);
    chk({nm, ".sig_out"},  sig_out, eo);
    chk({nm, ".rise"},     rise,    er);
    chk({nm, ".fall"},     fall,    ef);
    chk({nm, ".any_edge"}, {3'b000, any_edge}, {3'b000, |(er | ef)});
  endtask

  typedef struct {
    logic [3:0] vin;
    logic       en;
    logic [3:0] eout;
    logic [3:0] erise;
    logic [3:0] efall;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic [3:0] vin, logic e, logic [3:0] o, logic [3:0] r, logic [3:0] f);
    vec_t v;
    v.vin = vin; v.en = e; v.eout = o; v.erise = r; v.efall = f;
    tbl.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Clean rise on channel 0. It is loaded at edge 0 and appears after edge 5.
    for (int i = 0; i < 5; i++) add(4'b1001, 1'b1, 4'b1000, 4'b0000, 4'b0000);
    add(4'b1001, 1'b1, 4'b1001, 4'b0001, 4'b0000);
    add(4'b1001, 1'b1, 4'b1001, 4'b0000, 4'b0000);
    // Channel 2 rises and channel 3 falls in the same cycle.
    for (int i = 0; i < 5; i++) add(4'b0101, 1'b1, 4'b1001, 4'b0000, 4'b0000);
    add(4'b0101, 1'b1, 4'b0101, 4'b0100, 4'b1000);
    add(4'b0101, 1'b1, 4'b0101, 4'b0000, 4'b0000);
    // Bounce on channel 1: three cycles high is one short of completing.
    for (int i = 0; i < 3; i++) add(4'b0111, 1'b1, 4'b0101, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) add(4'b0101, 1'b1, 4'b0101, 4'b0000, 4'b0000);
    // The count restarted from zero, so a steady high needs the full latency.
    for (int i = 0; i < 5; i++) add(4'b0111, 1'b1, 4'b0101, 4'b0000, 4'b0000);
    add(4'b0111, 1'b1, 4'b0111, 4'b0010, 4'b0000);

    // Reset state
    #1 rst_n = 1'b0;
    #2 chk_all("reset", RV, 4'b0000, 4'b0000);
    #9 rst_n = 1'b1;                         // t=12; the next edge at t=15 is edge 0

    foreach (tbl[i]) begin
      sig_in = tbl[i].vin;
      en     = tbl[i].en;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].eout, tbl[i].erise, tbl[i].efall);
    end

    // Asynchronous reset mid-cycle with all inputs high. It lands just after a
    // rise pulse, which must clear with no clock edge.
    sig_in = 4'hF;
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", RV, 4'b0000, 4'b0000);
    #2 rst_n = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      tick();
      if (i < 5) chk_all($sformatf("post_rst%0d", i), RV, 4'b0000, 4'b0000);
      else       chk_all("post_rst_done", 4'hF, 4'b0111, 4'b0000);
    end

    // Enable freeze: two counted cycles, ten frozen cycles, then two more edges.
    sig_in = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all($sformatf("frz_pre%0d", i), 4'hF, 4'b0000, 4'b0000);
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all($sformatf("frz%0d", i), 4'hF, 4'b0000, 4'b0000);
    end
    en = 1'b1;
    tick();
    chk_all("frz_resume1", 4'hF, 4'b0000, 4'b0000);
    tick();
    chk_all("frz_resume2", 4'b1110, 4'b0000, 4'b0001);

    // Reset during a count discards it, and the full latency is needed afterwards.
    sig_in = 4'hF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all($sformatf("mc_pre%0d", i), 4'b1110, 4'b0000, 4'b0000);
    end
    #2 rst_n = 1'b0;
    #1 chk_all("mc_rst", RV, 4'b0000, 4'b0000);
    #2 rst_n = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      tick();
      if (i < 5) chk_all($sformatf("mc_post%0d", i), RV, 4'b0000, 4'b0000);
      else       chk_all("mc_done", 4'hF, 4'b0111, 4'b0000);
    end

    // Randomized run against the model, with occasional mid-cycle resets.
    #2 rst_n = 1'b0;
    sig_in = RV;
    model_reset();
    model_on = 1'b1;
    #2 rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk_all("rnd_rst", m_out, m_rise, m_fall);
        #2 rst_n = 1'b1;
      end
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 5) == 0) sig_in[c] = ~sig_in[c];
      en = ($urandom_range(0, 9) != 0);
      tick();
      chk_all($sformatf("rnd%0d", n), m_out, m_rise, m_fall);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
